// File: rtl/fetch_prefetch_buffer.sv
// Sequential instruction fetch into a DEPTH-entry {PC, inst} FIFO, flushed and restarted on REDIRECT.
// Latency: 2 edges from issue to INST_VALID. Backpressure: fetch issue stops once buffered plus in-flight reaches DEPTH.
module fetch_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic                     CLK,
    input  logic                     RSTn,
    output logic                     I_MEM_CSN,
    output logic [11:0]              I_MEM_ADDR,
    input  logic [31:0]              I_MEM_DI,
    output logic                     INST_VALID,
    output logic [31:0]              INST,
    output logic [11:0]              INST_PC,
    input  logic                     INST_READY,
    input  logic                     REDIRECT,
    input  logic [11:0]              REDIRECT_PC,
    input  logic                     FETCH_HALT,
    output logic [$clog2(DEPTH):0]   OCCUPANCY
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = CW + 1;

    logic [11:0]   fetch_pc;
    logic          pending;
    logic [11:0]   pending_pc;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          halted;
    logic [31:0]   hold_inst;
    logic [11:0]   hold_pc;

    logic [31:0]   inst_mem [DEPTH];
    logic [11:0]   pc_mem   [DEPTH];

    logic          pop;
    logic          push;
    logic          issue;
    logic [OW-1:0] occ_after;
    logic [11:0]   redirect_base;
    logic [11:0]   issue_pc;

    assign redirect_base = REDIRECT_PC & 12'hFFC;

    // occ_after is what the FIFO will hold once the in-flight word lands; it gates new issues.
    always_comb begin
        pop       = (count != '0) && INST_READY && !REDIRECT;
        push      = pending && !REDIRECT;
        occ_after = {1'b0, count} + OW'(pending) - OW'(pop);
        issue_pc  = REDIRECT ? redirect_base : fetch_pc;
        if (REDIRECT) begin
            issue = !halted && !FETCH_HALT;
        end else begin
            issue = !halted && !FETCH_HALT && (occ_after < OW'(DEPTH));
        end
    end

    always_ff @(posedge CLK) begin
        if (RSTn && push) begin
            inst_mem[wr_ptr] <= I_MEM_DI;
            pc_mem[wr_ptr]   <= pending_pc;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            fetch_pc   <= RESET_PC;
            pending    <= 1'b0;
            pending_pc <= 12'h000;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            halted     <= 1'b0;
            I_MEM_CSN  <= 1'b1;
            I_MEM_ADDR <= 12'h000;
            hold_inst  <= 32'h0;
            hold_pc    <= 12'h000;
        end else begin
            if (FETCH_HALT) begin
                halted <= 1'b1;
            end
            if (INST_VALID) begin
                hold_inst <= INST;
                hold_pc   <= INST_PC;
            end

            if (REDIRECT) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (!push && pop) begin
                    count <= count - CW'(1);
                end
            end

            if (issue) begin
                I_MEM_CSN  <= 1'b0;
                I_MEM_ADDR <= issue_pc;
                pending    <= 1'b1;
                pending_pc <= issue_pc;
                fetch_pc   <= issue_pc + 12'd4;
            end else begin
                I_MEM_CSN <= 1'b1;
                pending   <= 1'b0;
                if (REDIRECT) begin
                    fetch_pc <= redirect_base;
                end
            end
        end
    end

    // When empty, the last delivered head stays visible rather than a stale slot.
    assign INST_VALID = (count != '0);
    assign INST       = INST_VALID ? inst_mem[rd_ptr] : hold_inst;
    assign INST_PC    = INST_VALID ? pc_mem[rd_ptr]   : hold_pc;
    assign OCCUPANCY  = count;

endmodule
